mult_div_unit: RTL

- Iterative 32-bit multiply/divide unit for the MIPS datapath; owns the HI/LO registers.
- Executes MULT, MULTU, DIV, DIVU over 32 cycles; MTHI/MTLO write in one cycle.
- Sits directly upstream of the write-back 4:1 32-bit select, whose inputs include hi/lo for MFHI/MFLO.
- The control unit uses busy to stall the pipeline.

---
 rtl/mult_div_unit.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the MIPS HI/LO registers.
// One multiplier or quotient bit per cycle; MTHI/MTLO complete in a single cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in_data_a,
    input  logic [WIDTH-1:0] in_data_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic {
        S_IDLE,
        S_CALC
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [WIDTH-1:0]     orig_a_q, orig_a_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 div_zero_q, div_zero_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    // Operand magnitudes; 0x80000000 negates to itself and is used as an unsigned magnitude.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign a_neg = ~op[0] & in_data_a[WIDTH-1];
    assign b_neg = ~op[0] & in_data_b[WIDTH-1];
    assign a_mag = a_neg ? -in_data_a : in_data_a;
    assign b_mag = b_neg ? -in_data_b : in_data_b;

    // Multiply: acc = {partial product high half, remaining multiplier bits}.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                               : {1'b0, acc_q[2*WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
    logic [WIDTH:0]     div_trial;
    logic [WIDTH:0]     div_diff;
    logic               div_ok;
    logic [2*WIDTH-1:0] div_next;

    assign div_trial = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_trial - {1'b0, opnd_q};
    assign div_ok    = ~div_diff[WIDTH];
    assign div_next  = {(div_ok ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0]),
                        acc_q[WIDTH-2:0], div_ok};

    logic [2*WIDTH-1:0] iter_next;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed;
    logic [WIDTH-1:0]   rem_fixed;

    assign iter_next  = is_div_q ? div_next : mul_next;
    assign prod_fixed = neg_res_q ? -iter_next : iter_next;
    assign quo_fixed  = neg_res_q ? -iter_next[WIDTH-1:0] : iter_next[WIDTH-1:0];
    assign rem_fixed  = neg_rem_q ? -iter_next[2*WIDTH-1:WIDTH] : iter_next[2*WIDTH-1:WIDTH];

    // NOTE: every _d gets a default before the case so no path leaves a value unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        orig_a_d   = orig_a_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MTHI: hi_d = in_data_a;
                        OP_MTLO: lo_d = in_data_a;
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            state_d    = S_CALC;
                            cnt_d      = '0;
                            is_div_d   = op[1];
                            neg_res_d  = a_neg ^ b_neg;
                            neg_rem_d  = a_neg;
                            opnd_d     = op[1] ? b_mag : a_mag;
                            acc_d      = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                            div_zero_d = op[1] & (in_data_b == '0);
                            orig_a_d   = in_data_a;
                        end
                        default: ;
                    endcase
                end
            end
            S_CALC: begin
                acc_d = iter_next;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    if (!is_div_q) begin
                        hi_d = prod_fixed[2*WIDTH-1:WIDTH];
                        lo_d = prod_fixed[WIDTH-1:0];
                    end else if (div_zero_q) begin
                        hi_d = orig_a_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fixed;
                        lo_d = quo_fixed;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            orig_a_q   <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            orig_a_q   <= orig_a_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            done_q     <= done_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy = (state_q == S_CALC);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
